display_port: RTL and testbench

Memory-mapped output port on the 6502 bus that feeds the 8-bit `value` input of the decimal 7-segment display stage.
- CPU writes to one address are captured into a shadow register.
- The displayed value is committed only after writes stop for HOLD_CYCLES clocks. This hold-off keeps fast-changing counters from smearing the display.
- The shadow value can be read back by the CPU.

---
 rtl/display_port.sv | 112 +++++++++++
 tb/tb_display_port.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_port.sv
// CPU-visible output port: shadow register, hold-off commit to the 7-segment value, readback.
// Optional status register at ADDR+1 when DISPLAY_PORT_STATUS_EN is defined.
module display_port #(
    parameter logic [15:0] ADDR        = 16'hD000,
    parameter int          HOLD_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        we,
    input  logic        cpu_en,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [7:0]  value,
    output logic        value_update
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [23:0] RELOAD = (HOLD_CYCLES == 0) ? 24'(0) : 24'(HOLD_CYCLES - 1);

    state_t      state, state_next;
    logic [23:0] cnt, cnt_next;
    logic [7:0]  shadow;
    logic [7:0]  status;
    logic [7:0]  commit_val;
    logic        commit;
    logic        wr_d, rd_d, rd_s;

    assign wr_d = cpu_en && (addr == ADDR) && we;
    assign rd_d = cpu_en && (addr == ADDR) && !we;

`ifdef DISPLAY_PORT_STATUS_EN
    logic overrun;

    assign rd_s   = cpu_en && (addr == ADDR + 16'd1) && !we;
    assign status = {6'b0, overrun, state == HOLD};

    // A write landing in HOLD sets the flag even if a status read clears it on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun <= 1'b0;
        else if (wr_d && state == HOLD)
            overrun <= 1'b1;
        else if (rd_s)
            overrun <= 1'b0;
    end
`else
    assign rd_s   = 1'b0;
    assign status = 8'h00;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            shadow       <= '0;
            value        <= '0;
            value_update <= 1'b0;
            data_out     <= '0;
            data_oe      <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            value_update <= commit;
            data_oe      <= rd_d || rd_s;
            if (wr_d)
                shadow <= data_in;
            if (commit)
                value <= commit_val;
            if (rd_d)
                data_out <= shadow;
            else if (rd_s)
                data_out <= status;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        commit_val = shadow;
        if (HOLD_CYCLES == 0) begin
            commit     = wr_d;
            commit_val = data_in;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_d) begin
                        state_next = HOLD;
                        cnt_next   = RELOAD;
                    end
                end
                HOLD: begin
                    if (wr_d)
                        cnt_next = RELOAD;
                    else if (cnt != 24'd0)
                        cnt_next = cnt - 24'd1;
                    else begin
                        commit     = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_port.sv
// Scoreboard bench for display_port: driver feeds a timing model, monitor checks DUT outputs.
module tb_display_port;

    localparam logic [15:0] ADDR = 16'hD000;
    localparam int          HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic [7:0]  data_in = '0;
    logic        we = 1'b0;
    logic        cpu_en = 1'b0;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  value;
    logic        value_update;

    display_port #(.ADDR(ADDR), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .we(we), .cpu_en(cpu_en),
        .data_out(data_out), .data_oe(data_oe), .value(value), .value_update(value_update)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0]  val;
        int unsigned cyc;
    } commit_t;

    logic [7:0] read_q[$];
    commit_t    commit_q[$];

    // Reference model: the value last written appears HOLD edges after the last write.
    logic [7:0]  m_shadow;
    logic [7:0]  m_disp;
    bit          m_pending;
    bit          m_overrun;
    int unsigned m_deadline;

    task automatic model_reset();
        m_shadow  = 8'h00;
        m_disp    = 8'h00;
        m_pending = 0;
        m_overrun = 0;
        read_q.delete();
        commit_q.delete();
    endtask

    task automatic bus(input logic en, input logic [15:0] a, input logic w, input logic [7:0] d);
        bit          hit_d, hit_s;
        int unsigned e;
        commit_t     c;
        cpu_en  = en;
        addr    = a;
        we      = w;
        data_in = d;
        @(posedge clk);
        #1;
        e     = cyc;
        hit_d = en && (a == ADDR);
        hit_s = en && (a == ADDR + 16'd1);
`ifdef DISPLAY_PORT_STATUS_EN
        if (hit_s && !w) begin
            read_q.push_back({6'b0, m_overrun, m_pending});
            m_overrun = 0;
        end
`else
        if (hit_s) m_overrun = 0;
`endif
        if (hit_d && !w)
            read_q.push_back(m_shadow);
        if (hit_d && w) begin
            if (m_pending) m_overrun = 1;
            m_shadow = d;
            if (HOLD == 0) begin
                c.val = d; c.cyc = e;
                commit_q.push_back(c);
                m_disp = d;
            end else begin
                m_pending  = 1;
                m_deadline = e + HOLD;
            end
        end else if (m_pending && e == m_deadline) begin
            c.val = m_shadow; c.cyc = e;
            commit_q.push_back(c);
            m_disp    = m_shadow;
            m_pending = 0;
        end
        check("value_steady", value, m_disp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 16'h0000, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus(1'b1, a, 1'b1, d);
    endtask

    task automatic rd(input logic [15:0] a);
        bus(1'b1, a, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_value", value, 8'h00);
        check("rst_value_update", value_update, 1'b0);
        check("rst_data_oe", data_oe, 1'b0);
        cpu_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: every DUT output event must match the oldest expectation of its kind.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_oe) begin
                if (read_q.size() == 0)
                    check("spurious_data_oe", data_oe, 1'b0);
                else
                    check("read_data", data_out, read_q.pop_front());
            end
            if (value_update) begin
                if (commit_q.size() == 0)
                    check("spurious_value_update", value_update, 1'b0);
                else begin
                    commit_t c;
                    c = commit_q.pop_front();
                    check("commit_value", value, c.val);
                    check("commit_cycle", cyc, c.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Reset mid-run, then readback of the cleared shadow.
        wr(ADDR, 8'h3C);
        idle(HOLD + 2);
        do_reset();
        rd(ADDR);
        idle(2);

        // Single commit and restart-on-rewrite.
        wr(ADDR, 8'hA5);
        idle(HOLD + 2);
        wr(ADDR, 8'h11);
        idle(1);
        wr(ADDR, 8'h22);
        idle(HOLD + 2);

        // Readback and address decode.
        wr(ADDR, 8'h7F);
        rd(ADDR);
        wr(16'hD002, 8'h55);
        bus(1'b0, ADDR, 1'b1, 8'hEE);
        rd(ADDR);
        idle(HOLD + 2);

        // Reset while a commit is pending discards it.
        wr(ADDR, 8'h99);
        idle(1);
        do_reset();
        idle(10);
        check("midhold_value", value, 8'h00);

`ifdef DISPLAY_PORT_STATUS_EN
        wr(ADDR, 8'h01);
        wr(ADDR, 8'h02);
        rd(ADDR + 16'd1);
        idle(HOLD + 2);
        rd(ADDR + 16'd1);
        idle(2);
`endif

        for (int i = 0; i < 500; i++) begin
            int unsigned r;
            r = $urandom_range(0, 11);
            case (r)
                0, 1:    wr(ADDR, 8'($urandom));
                2:       rd(ADDR);
                3:       rd(ADDR + 16'd1);
                4:       wr(ADDR + 16'd1, 8'($urandom));
                5:       bus(1'($urandom), 16'($urandom), 1'($urandom), 8'($urandom));
                6:       bus(1'b0, ADDR, 1'($urandom), 8'($urandom));
                default: idle(1);
            endcase
        end
        idle(HOLD + 3);

        check("read_q_drained", read_q.size(), 0);
        check("commit_q_drained", commit_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
